// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

  // Reset and clear value of register idx.
  function automatic int unsigned rst_val(int unsigned idx, int unsigned even_v,
                                          int unsigned odd_v);
    return idx[0] ? odd_v : even_v;
  endfunction

  // Low bit of element idx in a packed array of w-bit elements.
  function automatic int unsigned slice_lo(int unsigned idx, int unsigned w);
    return idx * w;
  endfunction

  function automatic logic addr_ok(int unsigned addr, int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and clear signals of the multi-port register file.
interface regfile_mp_if #(
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8
) ();

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     wr_conflict;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data, clr_busy, wr_conflict
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
    output rd_data, clr_busy, wr_conflict
  );

endinterface

// File: rtl/regfile_wr_arb.sv
// Per-address write select (highest-index port wins) and collision detect.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_WR  = 1,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  output logic [DEPTH-1:0]         we_o,
  output logic [DEPTH*DATA_W-1:0]  wd_o,
  output logic                     conflict_o
);

  always_comb begin
    logic [ADDR_W-1:0] addr;
    addr       = '0;
    we_o       = '0;
    wd_o       = '0;
    conflict_o = 1'b0;
    // Ascending scan so a later port overwrites an earlier one.
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      addr = wr_addr_i[slice_lo(j, ADDR_W) +: ADDR_W];
      if (wr_en_i[j] && addr_ok(32'(addr), DEPTH) && !(ZERO_R0 != 0 && addr == '0)) begin
        if (we_o[addr]) begin
          conflict_o = 1'b1;
        end
        we_o[addr] = 1'b1;
        wd_o[slice_lo(32'(addr), DATA_W) +: DATA_W] = wr_data_i[slice_lo(j, DATA_W) +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parameterised multi-port register file with write bypass, optional zero
// register and a sequenced bulk-clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_R0  = 0,
  parameter int unsigned RST_EVEN = 0,
  parameter int unsigned RST_ODD  = 5
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  logic [DATA_W-1:0]        regs_q [DEPTH];
  clr_state_e               state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic                     clr_busy;
  logic                     clr_we;
  logic [NUM_WR-1:0]        wr_en_gated;
  logic [DEPTH-1:0]         arb_we;
  logic [DEPTH*DATA_W-1:0]  arb_wd;
  logic                     arb_conflict;
  logic                     wr_conflict_q;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;

  function automatic logic [DATA_W-1:0] init_of(int unsigned k);
    if (ZERO_R0 != 0 && k == 0) begin
      return '0;
    end
    return DATA_W'(rst_val(k, RST_EVEN, RST_ODD));
  endfunction

  // Port writes are suppressed while the clear engine owns the array.
  assign wr_en_gated = clr_busy ? '0 : bus.wr_en;

  regfile_wr_arb #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .NUM_WR  (NUM_WR),
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_wr_arb (
    .wr_en_i    (wr_en_gated),
    .wr_addr_i  (bus.wr_addr),
    .wr_data_i  (bus.wr_data),
    .we_o       (arb_we),
    .wd_o       (arb_wd),
    .conflict_o (arb_conflict)
  );

  // Clear FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear FSM: next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLR_IDLE: begin
        cnt_d = '0;
        if (bus.clr_req) begin
          state_d = CLR_RUN;
        end
      end
      CLR_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Clear FSM: outputs.
  always_comb begin
    clr_busy = (state_q == CLR_RUN);
    clr_we   = (state_q == CLR_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        regs_q[k] <= init_of(k);
      end
    end else if (clr_we) begin
      regs_q[cnt_q] <= init_of(32'(cnt_q));
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (arb_we[k]) begin
          regs_q[k] <= arb_wd[slice_lo(k, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    ra        = '0;
    val       = '0;
    rd_data_d = rd_data_q;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = bus.rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
      if (!addr_ok(32'(ra), DEPTH) || (ZERO_R0 != 0 && ra == '0)) begin
        val = '0;
      end else if (BYPASS != 0 && arb_we[ra]) begin
        // arb_we is all-zero during a clear, so bypass never applies then.
        val = arb_wd[slice_lo(32'(ra), DATA_W) +: DATA_W];
      end else begin
        val = regs_q[ra];
      end
      if (bus.rd_en[i]) begin
        rd_data_d[slice_lo(i, DATA_W) +: DATA_W] = val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      rd_data_q     <= rd_data_d;
      wr_conflict_q <= arb_conflict;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.clr_busy    = clr_busy;
  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parameterised multi-port register file. It is the next-generation general-purpose register store for the core, feeding operand latches and taking writeback results. It adds the following over the fixed 4x8 two-read/one-write file:
- configurable width, depth and port counts
- write-to-read bypass
- optional hard-wired zero register
- a sequenced bulk-clear engine with busy indication

Parameters:
DATA_W, 8, register width in bits
DEPTH, 4, number of registers (any value >= 2)
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports
ADDR_W, $clog2(DEPTH), address width (derived, do not override)
BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address
ZERO_R0, 0, 1 = register 0 reads as 0 and ignores writes
RST_EVEN, 0, reset/clear value of even-indexed registers
RST_ODD, 5, reset/clear value of odd-indexed registers

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, packed as above
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  packed write addresses
wr_data  in  NUM_WR*DATA_W  packed write data
clr_req  in  1  start bulk clear (level-sampled)
clr_busy  out  1  high while clear sequence is running
wr_conflict  out  1  one-cycle pulse: two or more write ports hit the same address in the previous cycle

Behaviour:
- Reset (rst_n low, async):
  - reg[k] = RST_ODD if k is odd, else RST_EVEN; reg[0] = 0 if ZERO_R0.
  - rd_data = 0, clr_busy = 0, wr_conflict = 0, FSM = IDLE, clear counter = 0.
- Read latency is one cycle.
  - rd_en[i] high at edge N: rd_data[i] after N = contents of rd_addr[i] as seen at N.
  - rd_en[i] low: rd_data[i] holds.
- Write: wr_en[j] high at edge N updates the register at N. It is visible to a non-bypassed read sampled at N+1.
- Bypass:
  - BYPASS=1: a read and an enabled write to the same address at the same edge returns the write data (winning port, below).
  - BYPASS=0: the read returns the old contents.
- Write collision: if several enabled ports target one address, the highest-index port wins. wr_conflict is high for exactly the following cycle.
- ZERO_R0=1:
  - writes to address 0 are dropped, no conflict flagged for them;
  - reads of address 0 return 0, including under bypass.
- Out-of-range addresses (DEPTH not a power of two, addr >= DEPTH):
  - writes are dropped;
  - reads return 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req is high at an edge; counter = 0; clr_busy high from the next cycle.
  - CLEAR: each cycle, reg[counter] gets its reset value and the counter increments.
  - When counter == DEPTH-1 that write completes and the FSM returns to IDLE. clr_busy falls on the same edge.
  - Total busy time is exactly DEPTH cycles.
  - clr_req during CLEAR is ignored; clr_req held high after completion starts a new clear.
  - Port writes during CLEAR are dropped and never flag a conflict.
  - Reads during CLEAR are serviced normally and return current (partially cleared) contents; bypass does not apply.
- rst_n asserted mid-clear aborts the sequence immediately. All state returns to reset values.

Decomposition:
- Package regfile_pkg:
  - function rst_val(index) returning RST_EVEN/RST_ODD selection (parameter-passed);
  - enum clr_state_e {CLR_IDLE, CLR_RUN};
  - helper for packed-array slicing widths.
- One sub-module, regfile_wr_arb: per-address winning-port select and conflict detect, combinational.
- Storage, read ports and the FSM stay in regfile_mp.

Test Plan:
- Reset, default params: read addrs 0..3 on both ports -> rd_data 0,5,0,5 one cycle after rd_en.
- Write 0xA5 to r2 and read r2 at the same edge, BYPASS=1 -> 0xA5 next cycle. With BYPASS=0 -> 0x00, then 0xA5 on the following read.
- NUM_WR=2: port0 writes 0x11, port1 writes 0x22, both to r1 -> r1 = 0x22; wr_conflict high exactly one cycle.
- ZERO_R0=1: write 0xFF to r0, read r0 via bypass and next cycle -> 0x00 both times; wr_conflict stays 0.
- Fill all regs with 0xEE, pulse clr_req -> clr_busy high 4 cycles.
  - Reading r3 in cycle 2 of busy -> 0xEE.
  - A write issued during busy is dropped.
  - After busy -> 0,5,0,5.
- Pulse clr_req, drop rst_n during busy cycle 2 -> clr_busy 0 immediately; all regs at reset values; FSM idle after rst_n release.
